// File: rtl/dcache_wb_buffer_if.sv
// Bundle between the write-back buffer, the data cache (push/query side)
// and the AXI write channel. The master modport is the buffer's own view.
interface dcache_wb_buffer_if #(
    parameter int LINE_WORDS = 16
);
    logic                    push_valid;
    logic                    push_ready;
    logic [31:0]             push_addr;
    logic [32*LINE_WORDS-1:0] push_data;
    logic [31:0]             query_addr;
    logic                    query_hit;
    logic                    empty;

    logic [3:0]              m_awid;
    logic [31:0]             m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic [1:0]              m_awlock;
    logic [3:0]              m_awcache;
    logic [2:0]              m_awprot;
    logic                    m_awvalid;
    logic                    m_awready;

    logic [3:0]              m_wid;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;

    logic                    m_bvalid;
    logic                    m_bready;

    modport master (
        input  push_valid, push_addr, push_data, query_addr,
               m_awready, m_wready, m_bvalid,
        output push_ready, query_hit, empty,
               m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
               m_awcache, m_awprot, m_awvalid,
               m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
    );

    modport slave (
        output push_valid, push_addr, push_data, query_addr,
               m_awready, m_wready, m_bvalid,
        input  push_ready, query_hit, empty,
               m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
               m_awcache, m_awprot, m_awvalid,
               m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
    );
endinterface

// File: rtl/dcache_wb_buffer.sv
// In-order queue of evicted dirty lines, each drained as one INCR burst on
// AW/W/B, with an address-hit check so the cache can stall refills.
module dcache_wb_buffer #(
    parameter int         LINE_WORDS   = 16,
    parameter int         OFFSET_WIDTH = 6,
    parameter int         DEPTH        = 2,
    parameter logic [3:0] AXI_ID       = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    dcache_wb_buffer_if.master  bus,
    output logic [1:0]          fsm_state
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - OFFSET_WIDTH;

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; a raised valid holds its payload until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [DEPTH-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [DEPTH];
    logic [32*LINE_WORDS-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]         head_q, tail_q;
    logic [CNT_W-1:0]         count_q;
    logic [BEAT_W-1:0]        beat_q;
    logic                     push_fire, pop_fire, last_beat, hit;
    logic                     unused_offset_bits;

    assign bus.push_ready = (count_q != CNT_W'(DEPTH));
    assign bus.empty      = (count_q == '0);
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign pop_fire       = (state_q == S_B) && bus.m_bvalid;
    assign last_beat      = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign fsm_state      = state_q;
    assign unused_offset_bits = ^{bus.push_addr[OFFSET_WIDTH-1:0],
                                  bus.query_addr[OFFSET_WIDTH-1:0]};

    assign bus.m_awid    = AXI_ID;
    assign bus.m_awlen   = 8'(LINE_WORDS - 1);
    assign bus.m_awsize  = 3'd2;
    assign bus.m_awburst = 2'b01;
    assign bus.m_awlock  = 2'b00;
    assign bus.m_awcache = 4'd0;
    assign bus.m_awprot  = 3'd0;
    assign bus.m_wid     = AXI_ID;
    assign bus.m_wstrb   = 4'hf;

    // The entry being drained still counts as a hit until its B handshake.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.query_addr[31:OFFSET_WIDTH])) begin
                hit = 1'b1;
            end
        end
    end
    assign bus.query_hit = hit;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            tag_q[tail_q]  <= bus.push_addr[31:OFFSET_WIDTH];
            data_q[tail_q] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_AW && bus.m_awready) begin
                beat_q <= '0;
            end else if (state_q == S_W && bus.m_wready) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.m_awvalid = 1'b0;
        bus.m_awaddr  = 32'd0;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = 32'd0;
        bus.m_wlast   = 1'b0;
        bus.m_bready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_AW;
            end
            S_AW: begin
                bus.m_awvalid = 1'b1;
                bus.m_awaddr  = {tag_q[head_q], {OFFSET_WIDTH{1'b0}}};
                if (bus.m_awready) state_d = S_W;
            end
            S_W: begin
                bus.m_wvalid = 1'b1;
                bus.m_wdata  = data_q[head_q][32*beat_q +: 32];
                bus.m_wlast  = last_beat;
                if (bus.m_wready && last_beat) state_d = S_B;
            end
            S_B: begin
                bus.m_bready = 1'b1;
                if (bus.m_bvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: stimulus pushes expected AW/W traffic
// into queues, a monitor pops and compares on every AXI handshake.
module tb_dcache_wb_buffer;
    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    dcache_wb_buffer_if #(.LINE_WORDS(16)) bus ();

    dcache_wb_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    logic [31:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  w_cnt = 0;
    bit  aw_en = 1'b1;
    bit  w_toggle = 1'b0;
    int  b_delay = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push one line; word i = base + 4i. Returns one cycle after the accepting edge.
    task automatic push_line(input logic [31:0] addr, input logic [31:0] base);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        bus.push_addr = addr;
        for (int i = 0; i < 16; i++) bus.push_data[32*i +: 32] = base + 32'(4*i);
        bus.push_valid = 1'b1;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (bus.push_ready) begin
                ok = 1'b1;
                exp_aw_q.push_back({addr[31:6], 6'b0});
                for (int i = 0; i < 16; i++) exp_w_q.push_back({i == 15, base + 32'(4*i)});
            end
            n++;
            @(posedge clk); #1;
        end
        bus.push_valid = 1'b0;
        if (!ok) check("push_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {63'd0, bus.empty}, 64'd1);
        @(posedge clk); #1;
    endtask

    // AXI slave model
    initial begin
        bit bhs;
        int b_cnt;
        b_cnt = 0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        forever begin
            @(negedge clk);
            bhs = bus.m_bvalid && bus.m_bready;
            @(posedge clk); #1;
            bus.m_awready = aw_en;
            bus.m_wready  = w_toggle ? !bus.m_wready : 1'b1;
            if (rst || bhs) begin
                bus.m_bvalid = 1'b0;
                b_cnt = 0;
            end else if (bus.m_bready && !bus.m_bvalid) begin
                if (b_cnt >= b_delay) bus.m_bvalid = 1'b1;
                else b_cnt++;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit          p_aw_stall, p_w_stall, p_b_stall, p_rst;
        logic [31:0] p_awaddr, p_wdata, exp_a;
        logic [32:0] exp_w;
        bit          p_wlast;
        p_aw_stall = 0; p_w_stall = 0; p_b_stall = 0; p_rst = 1;
        p_awaddr = 0; p_wdata = 0; p_wlast = 0;
        forever begin
            @(negedge clk);
            if (!p_rst) begin
                if (p_aw_stall) begin
                    check("aw_hold_valid", {63'd0, bus.m_awvalid}, 64'd1);
                    check("aw_hold_addr", {32'd0, bus.m_awaddr}, {32'd0, p_awaddr});
                end
                if (p_w_stall)
                    check("w_hold", {31'd0, bus.m_wvalid, bus.m_wlast, bus.m_wdata},
                          {31'd0, 1'b1, p_wlast, p_wdata});
                if (p_b_stall) check("b_hold", {63'd0, bus.m_bready}, 64'd1);
            end
            if (bus.m_awvalid && bus.m_awready) begin
                if (exp_aw_q.size() == 0) begin
                    check("aw_unexpected", {32'd0, bus.m_awaddr}, 64'hffff_ffff_ffff_ffff);
                end else begin
                    exp_a = exp_aw_q.pop_front();
                    check("aw_addr", {32'd0, bus.m_awaddr}, {32'd0, exp_a});
                    check("aw_consts",
                          {30'd0, bus.m_awid, bus.m_awlen, bus.m_awsize, bus.m_awburst,
                           bus.m_awlock, bus.m_awcache, bus.m_awprot, bus.m_wid, bus.m_wstrb},
                          {30'd0, 4'd1, 8'h0f, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 4'hf});
                end
            end
            if (bus.m_wvalid && bus.m_wready) begin
                w_cnt++;
                if (exp_w_q.size() == 0) begin
                    check("w_unexpected", {31'd0, bus.m_wlast, bus.m_wdata}, 64'hffff_ffff_ffff_ffff);
                end else begin
                    exp_w = exp_w_q.pop_front();
                    check("w_beat", {31'd0, bus.m_wlast, bus.m_wdata}, {31'd0, exp_w});
                end
            end
            p_aw_stall = bus.m_awvalid && !bus.m_awready;
            p_w_stall  = bus.m_wvalid && !bus.m_wready;
            p_b_stall  = bus.m_bready && !bus.m_bvalid;
            p_awaddr   = bus.m_awaddr;
            p_wdata    = bus.m_wdata;
            p_wlast    = bus.m_wlast;
            p_rst      = rst;
        end
    end

    // Stimulus
    initial begin
        int n, bcyc, wb;
        bit held;
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_addr  = '0;
        bus.push_data  = '0;
        bus.query_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_awvalid", {63'd0, bus.m_awvalid}, 64'd0);
        check("rst_wvalid", {63'd0, bus.m_wvalid}, 64'd0);
        check("rst_wlast", {63'd0, bus.m_wlast}, 64'd0);
        check("rst_bready", {63'd0, bus.m_bready}, 64'd0);
        check("rst_awaddr", {32'd0, bus.m_awaddr}, 64'd0);
        check("rst_wdata", {32'd0, bus.m_wdata}, 64'd0);
        check("rst_push_ready", {63'd0, bus.push_ready}, 64'd1);
        check("rst_empty", {63'd0, bus.empty}, 64'd1);
        check("rst_query_hit", {63'd0, bus.query_hit}, 64'd0);
        check("rst_state", {62'd0, fsm_state}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single line + hazard
        wb = w_cnt;
        push_line(32'h8000_0047, 32'h8000_0040);
        bus.query_addr = 32'h8000_007C;
        @(negedge clk);
        check("t1_empty_c1", {63'd0, bus.empty}, 64'd0);
        check("t1_hit_c1", {63'd0, bus.query_hit}, 64'd1);
        check("t1_awvalid_c1", {63'd0, bus.m_awvalid}, 64'd0);
        bus.query_addr = 32'h8000_0080;
        #1;
        check("t1_miss_next_line", {63'd0, bus.query_hit}, 64'd0);
        bus.query_addr = 32'h8000_007C;
        @(negedge clk);
        check("t1_awvalid_c2", {63'd0, bus.m_awvalid}, 64'd1);
        check("t1_awaddr_c2", {32'd0, bus.m_awaddr}, 64'h8000_0040);
        n = 2;
        held = 1'b1;
        while (!bus.empty && n < 60) begin
            if (!bus.query_hit) held = 1'b0;
            @(negedge clk);
            n++;
        end
        check("t1_hit_held", {63'd0, held}, 64'd1);
        check("t1_drain_cycles", 64'(n), 64'd20);
        check("t1_hit_after_b", {63'd0, bus.query_hit}, 64'd0);
        check("t1_beats", 64'(w_cnt - wb), 64'd16);
        @(posedge clk); #1;

        // Full buffer
        aw_en = 1'b0;
        push_line(32'h8000_0000, 32'h8000_0000);
        push_line(32'h8000_1000, 32'h8000_1000);
        bus.push_addr  = 32'h8000_2000;
        bus.push_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_push_ready", {63'd0, bus.push_ready}, 64'd0);
            @(posedge clk); #1;
        end
        bus.push_valid = 1'b0;
        @(negedge clk);
        check("full_aw_waiting", {31'd0, bus.m_awvalid, bus.m_awaddr}, {31'd0, 1'b1, 32'h8000_0000});
        @(posedge clk); #1;
        wb = w_cnt;
        aw_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.push_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("full_ready_after_first_b", {31'd0, bus.push_ready, 32'(w_cnt - wb)}, {31'd0, 1'b1, 32'd16});
        @(posedge clk); #1;
        wait_empty(80);
        check("full_beats", 64'(w_cnt - wb), 64'd32);

        // Backpressure
        w_toggle = 1'b1;
        b_delay  = 5;
        wb = w_cnt;
        push_line(32'h8000_4000, 32'h8000_4000);
        n = 0;
        bcyc = 0;
        @(negedge clk);
        while (!bus.empty && n < 120) begin
            if (bus.m_bready) bcyc++;
            @(negedge clk);
            n++;
        end
        check("bp_drained", {63'd0, bus.empty}, 64'd1);
        check("bp_beats", 64'(w_cnt - wb), 64'd16);
        check("bp_bready_cycles", 64'(bcyc), 64'd6);
        @(posedge clk); #1;
        w_toggle = 1'b0;
        b_delay  = 0;
        repeat (2) begin @(posedge clk); #1; end

        // Simultaneous push and pop
        push_line(32'h8000_6000, 32'h8000_6000);
        n = 0;
        @(negedge clk);
        while (!(bus.m_bready && bus.m_bvalid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("sim_b_reached", {63'd0, bus.m_bready && bus.m_bvalid}, 64'd1);
        check("sim_push_ready", {63'd0, bus.push_ready}, 64'd1);
        bus.push_addr = 32'h8000_3000;
        for (int i = 0; i < 16; i++) bus.push_data[32*i +: 32] = 32'h8000_3000 + 32'(4*i);
        bus.push_valid = 1'b1;
        exp_aw_q.push_back(32'h8000_3000);
        for (int i = 0; i < 16; i++) exp_w_q.push_back({i == 15, 32'h8000_3000 + 32'(4*i)});
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
        @(negedge clk);
        check("sim_idle_count1", {61'd0, fsm_state, bus.empty, bus.push_ready}, {61'd0, 2'd0, 1'b0, 1'b1});
        @(negedge clk);
        check("sim_aw", {29'd0, fsm_state, bus.m_awvalid, bus.m_awaddr}, {29'd0, 2'd1, 1'b1, 32'h8000_3000});
        @(posedge clk); #1;
        wait_empty(60);

        // Reset at W beat 5
        bus.query_addr = 32'h8000_7000;
        wb = w_cnt;
        push_line(32'h8000_7000, 32'h8000_7000);
        n = 0;
        while ((w_cnt - wb) != 5 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstw_reached_beat5", 64'(w_cnt - wb), 64'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_aw_q.delete();
        exp_w_q.delete();
        @(negedge clk);
        check("rstw_outputs",
              {58'd0, bus.m_wvalid, bus.m_awvalid, bus.empty, bus.query_hit, bus.push_ready, bus.m_bready},
              {58'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        check("rstw_state", {62'd0, fsm_state}, 64'd0);
        @(posedge clk); #1;
        wb = w_cnt;
        push_line(32'h8000_8000, 32'h8000_8000);
        wait_empty(60);
        check("rstw_repush_beats", 64'(w_cnt - wb), 64'd16);

        repeat (3) begin @(posedge clk); #1; end
        check("aw_queue_drained", 64'(exp_aw_q.size()), 64'd0);
        check("w_queue_drained", 64'(exp_w_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
